// File: rtl/alu_arbiter_2p_if.sv
// ---------------------------------------------------------------------------
// alu_arbiter_2p_if
// Request/response bundle between two issue sources and the shared ALU
// arbiter.
//
// Signals:
//   req_valid[1:0]  requester -> arbiter  bit i: port i presents an operation
//   req_ready[1:0]  arbiter -> requester  bit i: port i accepted this cycle
//   req_op0/1       requester -> arbiter  opcode per port (OP_W bits)
//   req_a0/1        requester -> arbiter  operand a per port (WIDTH bits)
//   req_b0/1        requester -> arbiter  operand b per port (WIDTH bits)
//   rsp_valid[1:0]  arbiter -> requester  bit i: result for port i available
//   rsp_ready[1:0]  requester -> arbiter  bit i: port i consumes its result
//   rsp_res         arbiter -> requester  registered result, shared
//   rsp_zero        arbiter -> requester  registered zero flag, shared
//
// Modports: master = requester side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface alu_arbiter_2p_if #(
  parameter int WIDTH = 16,
  parameter int OP_W  = 3
);
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [OP_W-1:0]  req_op0;
  logic [OP_W-1:0]  req_op1;
  logic [WIDTH-1:0] req_a0;
  logic [WIDTH-1:0] req_a1;
  logic [WIDTH-1:0] req_b0;
  logic [WIDTH-1:0] req_b1;
  logic [1:0]       rsp_valid;
  logic [1:0]       rsp_ready;
  logic [WIDTH-1:0] rsp_res;
  logic             rsp_zero;

  modport master (
    output req_valid, req_op0, req_op1, req_a0, req_a1, req_b0, req_b1,
    output rsp_ready,
    input  req_ready, rsp_valid, rsp_res, rsp_zero
  );

  modport slave (
    input  req_valid, req_op0, req_op1, req_a0, req_a1, req_b0, req_b1,
    input  rsp_ready,
    output req_ready, rsp_valid, rsp_res, rsp_zero
  );
endinterface

// File: rtl/alu_arbiter_2p.sv
// ---------------------------------------------------------------------------
// alu_arbiter_2p
// Shares one combinational alu_16_bit between two requesters with
// round-robin arbitration. One operation is in flight at a time:
// IDLE (accept) -> EXEC (ALU evaluates latched operands, result registered)
// -> RESP (result held until the winning port takes it) -> IDLE.
//
// Ports:
//   clk         rising-edge clock
//   reset_n     asynchronous active-low reset
//   bus         alu_arbiter_2p_if.slave request/response bundle
//   grant_cnt0  saturating accept counter for port 0 (ALU_ARB_CNT_EN only)
//   grant_cnt1  saturating accept counter for port 1 (ALU_ARB_CNT_EN only)
//
// Optional feature macro: ALU_ARB_CNT_EN adds the grant counters.
//
// alu_16_bit opcodes (4-bit, upper bit zero from this block):
//   0 add, 1 and, 2 or, 3 slt (signed, result 0/1), 4 sub,
//   5 sll by b[3:0], 6 srl by b[3:0], 7 bne (result 1 when a != b),
//   zero_bit = (res == 0).
// ---------------------------------------------------------------------------
module alu_16_bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [3:0]  alu_op,
  output logic [15:0] res,
  output logic        zero_bit
);
  always_comb begin
    res = 16'h0000;
    case (alu_op)
      4'd0: res = a + b;
      4'd1: res = a & b;
      4'd2: res = a | b;
      4'd3: res = {15'b0, $signed(a) < $signed(b)};
      4'd4: res = a - b;
      4'd5: res = a << b[3:0];
      4'd6: res = a >> b[3:0];
      4'd7: res = {15'b0, a != b};
      default: res = 16'h0000;
    endcase
    zero_bit = (res == 16'h0000);
  end
endmodule

module alu_arbiter_2p #(
  parameter int WIDTH = 16,
  parameter int OP_W  = 3,
  parameter int CNT_W = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  alu_arbiter_2p_if.slave     bus
`ifdef ALU_ARB_CNT_EN
  ,
  output logic [CNT_W-1:0]    grant_cnt0,
  output logic [CNT_W-1:0]    grant_cnt1
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             win_q, win_d;
  logic [OP_W-1:0]  op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             zero_q, zero_d;

  logic             win_now;
  logic             accept;
  logic [WIDTH-1:0] alu_res;
  logic             alu_zero;

  // The ALU only ever sees the latched operands, never the live request.
  alu_16_bit u_alu (
    .a        (a_q),
    .b        (b_q),
    .alu_op   ({{(4-OP_W){1'b0}}, op_q}),
    .res      (alu_res),
    .zero_bit (alu_zero)
  );

  // Round-robin pick: on a tie the port that did not win last time goes.
  // Acceptance is gated by reset_n so req_ready stays low while reset is held.
  always_comb begin
    win_now = 1'b0;
    if (bus.req_valid == 2'b11) begin
      win_now = ~last_grant_q;
    end else if (bus.req_valid[1]) begin
      win_now = 1'b1;
    end
    accept = (state_q == IDLE) && reset_n && (|bus.req_valid);
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    win_d         = win_q;
    op_d          = op_q;
    a_d           = a_q;
    b_d           = b_q;
    res_d         = res_q;
    zero_d        = zero_q;
    bus.req_ready = 2'b00;
    bus.rsp_valid = 2'b00;

    case (state_q)
      IDLE: begin
        if (accept) begin
          bus.req_ready = win_now ? 2'b10 : 2'b01;
          win_d         = win_now;
          last_grant_d  = win_now;
          op_d          = win_now ? bus.req_op1 : bus.req_op0;
          a_d           = win_now ? bus.req_a1  : bus.req_a0;
          b_d           = win_now ? bus.req_b1  : bus.req_b0;
          state_d       = EXEC;
        end
      end
      EXEC: begin
        res_d   = alu_res;
        zero_d  = alu_zero;
        state_d = RESP;
      end
      RESP: begin
        bus.rsp_valid = win_q ? 2'b10 : 2'b01;
        // Only the winner's rsp_ready matters here.
        if (bus.rsp_ready[win_q]) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.rsp_res  = res_q;
  assign bus.rsp_zero = zero_q;

  // State and datapath registers; last_grant resets to 1 so port 0 wins
  // the first tie after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      win_q        <= 1'b0;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      res_q        <= '0;
      zero_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      win_q        <= win_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      res_q        <= res_d;
      zero_q       <= zero_d;
    end
  end

`ifdef ALU_ARB_CNT_EN
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;

  // Per-port accept counters that stick at all-ones instead of wrapping.
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (accept && !win_now && (cnt0_q != {CNT_W{1'b1}})) begin
      cnt0_d = cnt0_q + CNT_W'(1);
    end
    if (accept && win_now && (cnt1_q != {CNT_W{1'b1}})) begin
      cnt1_d = cnt1_q + CNT_W'(1);
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign grant_cnt0 = cnt0_q;
  assign grant_cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_alu_arbiter_2p.sv
// ---------------------------------------------------------------------------
// tb_alu_arbiter_2p
// Self-checking bench for alu_arbiter_2p: directed scenarios plus a
// randomized run against a behavioural model (round-robin winner rule and
// plain-arithmetic ALU results). Define ALU_ARB_CNT_EN to also exercise the
// grant counters.
// ---------------------------------------------------------------------------
module tb_alu_arbiter_2p;
  localparam int WIDTH = 16;
  localparam int OP_W  = 3;
  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  alu_arbiter_2p_if #(.WIDTH(WIDTH), .OP_W(OP_W)) bus ();

`ifdef ALU_ARB_CNT_EN
  logic [CNT_W-1:0] grant_cnt0;
  logic [CNT_W-1:0] grant_cnt1;
`endif

  alu_arbiter_2p #(.WIDTH(WIDTH), .OP_W(OP_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus)
`ifdef ALU_ARB_CNT_EN
    ,
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1)
`endif
  );

  int   checks = 0;
  int   errors = 0;
  logic exp_last;

  // Reference ALU from the opcode table, plain arithmetic.
  function automatic logic [15:0] ref_alu(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    int sa, sb;
    sa = int'($signed(a));
    sb = int'($signed(b));
    case (op)
      3'd0: return a + b;
      3'd1: return a & b;
      3'd2: return a | b;
      3'd3: return (sa < sb) ? 16'd1 : 16'd0;
      3'd4: return a - b;
      3'd5: return 16'((32'(a) * (32'd1 << b[3:0])));
      3'd6: return 16'(32'(a) / (32'd1 << b[3:0]));
      default: return (a != b) ? 16'd1 : 16'd0;
    endcase
  endfunction

  // Round-robin rule: a tie goes to the port that did not win last.
  function automatic logic pick(input logic [1:0] v, input logic last);
    if (v == 2'b11) return !last;
    return v[1];
  endfunction

  task automatic set_ops(input logic [2:0] o0, input logic [15:0] a0, input logic [15:0] b0,
                         input logic [2:0] o1, input logic [15:0] a1, input logic [15:0] b1);
    bus.req_op0 = o0; bus.req_a0 = a0; bus.req_b0 = b0;
    bus.req_op1 = o1; bus.req_a1 = a1; bus.req_b1 = b1;
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    exp_last = 1'b1;
  endtask

  // Drives one full transaction from IDLE and returns what was observed.
  task automatic do_txn(input logic [1:0] v, input int hold,
                        output logic [1:0] rdy, output logic [1:0] exec_vld,
                        output logic [1:0] vld, output logic [15:0] res, output logic zero);
    bus.req_valid = v;
    @(negedge clk); rdy = bus.req_ready;
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    @(negedge clk); exec_vld = bus.rsp_valid;
    @(posedge clk);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      bus.rsp_ready = ~bus.rsp_valid;
    end
    @(negedge clk);
    vld  = bus.rsp_valid;
    res  = bus.rsp_res;
    zero = bus.rsp_zero;
    bus.rsp_ready = vld;
    @(posedge clk); #1;
    bus.rsp_ready = 2'b00;
  endtask

  task automatic test_reset();
    bus.req_valid = 2'b11;
    bus.rsp_ready = 2'b00;
    set_ops(3'd0, 16'h1111, 16'h2222, 3'd0, 16'h3333, 16'h4444);
    #2 reset_n = 1'b0;
    @(negedge clk);
    checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("[TB] FAIL reset_req_ready: got %b expected 00", bus.req_ready); end
    checks++; if (bus.rsp_valid !== 2'b00) begin errors++; $display("[TB] FAIL reset_rsp_valid: got %b expected 00", bus.rsp_valid); end
    checks++; if (bus.rsp_res !== 16'h0000) begin errors++; $display("[TB] FAIL reset_rsp_res: got %h expected 0000", bus.rsp_res); end
    checks++; if (bus.rsp_zero !== 1'b0) begin errors++; $display("[TB] FAIL reset_rsp_zero: got %b expected 0", bus.rsp_zero); end
    @(posedge clk); #1;
    reset_n = 1'b1;
    bus.req_valid = 2'b00;
    exp_last = 1'b1;
  endtask

  task automatic test_single_add();
    logic [1:0] rdy, ev, vld; logic [15:0] res; logic zero;
    set_ops(3'd0, 16'h0F0F, 16'h0F0F, 3'd0, 16'h0000, 16'h0000);
    do_txn(2'b01, 0, rdy, ev, vld, res, zero);
    exp_last = 1'b0;
    checks++; if (rdy !== 2'b01) begin errors++; $display("[TB] FAIL add_req_ready: got %b expected 01", rdy); end
    checks++; if (ev !== 2'b00) begin errors++; $display("[TB] FAIL add_exec_rsp_valid: got %b expected 00", ev); end
    checks++; if (vld !== 2'b01) begin errors++; $display("[TB] FAIL add_rsp_valid: got %b expected 01", vld); end
    checks++; if (res !== 16'h1E1E) begin errors++; $display("[TB] FAIL add_res: got %h expected 1e1e", res); end
    checks++; if (zero !== 1'b0) begin errors++; $display("[TB] FAIL add_zero: got %b expected 0", zero); end
  endtask

  task automatic test_single_sub();
    logic [1:0] rdy, ev, vld; logic [15:0] res; logic zero;
    set_ops(3'd0, 16'h0000, 16'h0000, 3'd4, 16'h0F0F, 16'h0F0F);
    do_txn(2'b10, 1, rdy, ev, vld, res, zero);
    exp_last = 1'b1;
    checks++; if (rdy !== 2'b10) begin errors++; $display("[TB] FAIL sub_req_ready: got %b expected 10", rdy); end
    checks++; if (vld !== 2'b10) begin errors++; $display("[TB] FAIL sub_rsp_valid: got %b expected 10", vld); end
    checks++; if (res !== 16'h0000) begin errors++; $display("[TB] FAIL sub_res: got %h expected 0000", res); end
    checks++; if (zero !== 1'b1) begin errors++; $display("[TB] FAIL sub_zero: got %b expected 1", zero); end
  endtask

  task automatic test_ties();
    logic [1:0] rdy, ev, vld, exp_rdy; logic [15:0] res, exp_res; logic zero, win;
    pulse_reset();
    set_ops(3'd1, 16'hF0F0, 16'h0F0F, 3'd2, 16'hF0F0, 16'h0F0F);
    for (int i = 0; i < 6; i++) begin
      do_txn(2'b11, 0, rdy, ev, vld, res, zero);
      win     = pick(2'b11, exp_last);
      exp_rdy = win ? 2'b10 : 2'b01;
      exp_res = win ? 16'hFFFF : 16'h0000;
      exp_last = win;
      checks++; if (rdy !== exp_rdy) begin errors++; $display("[TB] FAIL tie%0d_req_ready: got %b expected %b", i, rdy, exp_rdy); end
      checks++; if (vld !== exp_rdy) begin errors++; $display("[TB] FAIL tie%0d_rsp_valid: got %b expected %b", i, vld, exp_rdy); end
      checks++; if (res !== exp_res) begin errors++; $display("[TB] FAIL tie%0d_res: got %h expected %h", i, res, exp_res); end
    end
  endtask

  task automatic test_hold();
    set_ops(3'd0, 16'h1234, 16'h1111, 3'd4, 16'h5555, 16'h1111);
    bus.req_valid = 2'b01;
    @(negedge clk);
    checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("[TB] FAIL hold_req_ready0: got %b expected 01", bus.req_ready); end
    @(posedge clk); #1;
    exp_last = 1'b0;
    bus.req_valid = 2'b10;
    @(negedge clk);
    @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.rsp_ready = 2'b10;
      checks++; if (bus.rsp_valid !== 2'b01) begin errors++; $display("[TB] FAIL hold%0d_rsp_valid: got %b expected 01", i, bus.rsp_valid); end
      checks++; if (bus.rsp_res !== 16'h2345) begin errors++; $display("[TB] FAIL hold%0d_res: got %h expected 2345", i, bus.rsp_res); end
      checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("[TB] FAIL hold%0d_req_ready: got %b expected 00", i, bus.req_ready); end
    end
    @(negedge clk);
    bus.rsp_ready = 2'b01;
    @(posedge clk); #1;
    bus.rsp_ready = 2'b00;
    @(negedge clk);
    checks++; if (bus.req_ready !== 2'b10) begin errors++; $display("[TB] FAIL hold_req_ready1: got %b expected 10", bus.req_ready); end
    @(posedge clk); #1;
    exp_last = 1'b1;
    bus.req_valid = 2'b00;
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    checks++; if (bus.rsp_valid !== 2'b10) begin errors++; $display("[TB] FAIL hold_rsp_valid1: got %b expected 10", bus.rsp_valid); end
    checks++; if (bus.rsp_res !== 16'h4444) begin errors++; $display("[TB] FAIL hold_res1: got %h expected 4444", bus.rsp_res); end
    bus.rsp_ready = 2'b10;
    @(posedge clk); #1;
    bus.rsp_ready = 2'b00;
  endtask

  task automatic test_reset_mid();
    logic [1:0] rdy, ev, vld; logic [15:0] res; logic zero;
    set_ops(3'd4, 16'h0008, 16'h0003, 3'd0, 16'h0001, 16'h0001);
    do_txn(2'b01, 0, rdy, ev, vld, res, zero);
    exp_last = 1'b0;
    checks++; if (res !== 16'h0005) begin errors++; $display("[TB] FAIL mid_pre_res: got %h expected 0005", res); end
    bus.req_valid = 2'b11;
    @(negedge clk);
    checks++; if (bus.req_ready !== 2'b10) begin errors++; $display("[TB] FAIL mid_tie_req_ready: got %b expected 10", bus.req_ready); end
    @(posedge clk);
    @(negedge clk); #1;
    reset_n = 1'b0;
    #1;
    checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("[TB] FAIL mid_req_ready: got %b expected 00", bus.req_ready); end
    checks++; if (bus.rsp_valid !== 2'b00) begin errors++; $display("[TB] FAIL mid_rsp_valid: got %b expected 00", bus.rsp_valid); end
    checks++; if (bus.rsp_res !== 16'h0000) begin errors++; $display("[TB] FAIL mid_rsp_res: got %h expected 0000", bus.rsp_res); end
    checks++; if (bus.rsp_zero !== 1'b0) begin errors++; $display("[TB] FAIL mid_rsp_zero: got %b expected 0", bus.rsp_zero); end
    @(posedge clk); #1;
    reset_n = 1'b1;
    exp_last = 1'b1;
    @(negedge clk);
    checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("[TB] FAIL mid_regrant: got %b expected 01", bus.req_ready); end
    @(posedge clk); #1;
    exp_last = 1'b0;
    bus.req_valid = 2'b00;
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    checks++; if (bus.rsp_valid !== 2'b01) begin errors++; $display("[TB] FAIL mid_post_rsp_valid: got %b expected 01", bus.rsp_valid); end
    checks++; if (bus.rsp_res !== 16'h0005) begin errors++; $display("[TB] FAIL mid_post_res: got %h expected 0005", bus.rsp_res); end
    bus.rsp_ready = 2'b01;
    @(posedge clk); #1;
    bus.rsp_ready = 2'b00;
  endtask

  task automatic test_random();
    logic [1:0] v, rdy, ev, vld, exp_rdy; logic [15:0] res, exp_res; logic zero, win;
    logic [2:0] o0, o1; logic [15:0] a0, b0, a1, b1;
    for (int i = 0; i < 40; i++) begin
      v  = 2'($urandom_range(1, 3));
      o0 = 3'($urandom_range(0, 7)); o1 = 3'($urandom_range(0, 7));
      a0 = 16'($urandom); b0 = 16'($urandom);
      a1 = 16'($urandom); b1 = (i % 5 == 0) ? a1 : 16'($urandom);
      set_ops(o0, a0, b0, o1, a1, b1);
      do_txn(v, $urandom_range(0, 3), rdy, ev, vld, res, zero);
      win      = pick(v, exp_last);
      exp_last = win;
      exp_rdy  = win ? 2'b10 : 2'b01;
      exp_res  = win ? ref_alu(o1, a1, b1) : ref_alu(o0, a0, b0);
      checks++; if (rdy !== exp_rdy) begin errors++; $display("[TB] FAIL rnd%0d_req_ready: got %b expected %b", i, rdy, exp_rdy); end
      checks++; if (ev !== 2'b00) begin errors++; $display("[TB] FAIL rnd%0d_exec_valid: got %b expected 00", i, ev); end
      checks++; if (vld !== exp_rdy) begin errors++; $display("[TB] FAIL rnd%0d_rsp_valid: got %b expected %b", i, vld, exp_rdy); end
      checks++; if (res !== exp_res) begin errors++; $display("[TB] FAIL rnd%0d_res: got %h expected %h", i, res, exp_res); end
      checks++; if (zero !== (exp_res == 16'h0000)) begin errors++; $display("[TB] FAIL rnd%0d_zero: got %b expected %b", i, zero, exp_res == 16'h0000); end
    end
  endtask

`ifdef ALU_ARB_CNT_EN
  task automatic test_counters();
    logic [1:0] rdy, ev, vld; logic [15:0] res; logic zero;
    pulse_reset();
    checks++; if (grant_cnt0 !== 8'd0) begin errors++; $display("[TB] FAIL cnt_reset0: got %0d expected 0", grant_cnt0); end
    set_ops(3'd0, 16'h0001, 16'h0002, 3'd1, 16'h00FF, 16'h0F0F);
    for (int i = 0; i < 3; i++) do_txn(2'b01, 0, rdy, ev, vld, res, zero);
    for (int i = 0; i < 2; i++) do_txn(2'b10, 0, rdy, ev, vld, res, zero);
    checks++; if (grant_cnt0 !== 8'd3) begin errors++; $display("[TB] FAIL cnt0_small: got %0d expected 3", grant_cnt0); end
    checks++; if (grant_cnt1 !== 8'd2) begin errors++; $display("[TB] FAIL cnt1_small: got %0d expected 2", grant_cnt1); end
    for (int i = 0; i < 300; i++) do_txn(2'b01, 0, rdy, ev, vld, res, zero);
    exp_last = 1'b0;
    checks++; if (grant_cnt0 !== 8'd255) begin errors++; $display("[TB] FAIL cnt0_sat: got %0d expected 255", grant_cnt0); end
    checks++; if (grant_cnt1 !== 8'd2) begin errors++; $display("[TB] FAIL cnt1_after_sat: got %0d expected 2", grant_cnt1); end
  endtask
`endif

  initial begin
    #2000000;
    errors++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.req_valid = 2'b00;
    bus.rsp_ready = 2'b00;
    set_ops(3'd0, 16'h0000, 16'h0000, 3'd0, 16'h0000, 16'h0000);
    exp_last = 1'b1;
    test_reset();
    test_single_add();
    test_single_sub();
    test_ties();
    test_hold();
    test_reset_mid();
    test_random();
`ifdef ALU_ARB_CNT_EN
    test_counters();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
